pipe_stage_skid: RTL and testbench

Generic elastic pipeline-stage register, the parametrised successor to the fixed decode-to-execute flop. It carries a zero-on-bubble control field plus a don't-care data field between any two core stages. It uses a valid/ready handshake with an optional 2-entry skid buffer, so stalls propagate without combinational ready paths. It also provides synchronous flush, an external hold, and saturating performance counters.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_sat_counter.sv | 19 +
 rtl/pipe_stage_skid.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register: occupancy
// state encodings and default field widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam int CTRL_W_DEF = 16;
  localparam int DATA_W_DEF = 140;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: adds one per cycle with inc high and sticks at all-ones.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with optional skid entry, flush, hold and
// saturating stall/bubble/flush counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              hold,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [1:0]        state_dbg
);

  // Handshake: an item moves on a side exactly in a cycle where valid and ready
  // are both high at the clock edge; valid never depends on ready, and hold
  // simply masks out_ready on the downstream side.
  localparam bit USE_SKID = (SKID != 0);

  state_t            state, state_n;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              er, out_fire, in_fire, in_ready_q;
  logic              ld_main_in, ld_main_skid, ld_skid, clr_main, clr_skid;

  assign er        = out_ready & ~hold;
  assign out_valid = (state != ST_EMPTY);
  assign out_fire  = out_valid & er;
  assign in_fire   = in_valid & in_ready;
  assign in_ready  = USE_SKID ? in_ready_q : (~rst & ((state == ST_EMPTY) | er));
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign state_dbg = state;

  always_comb begin
    state_n      = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    clr_main     = 1'b0;
    clr_skid     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          state_n    = ST_ONE;
          ld_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          state_n = ST_TWO;
          ld_skid = 1'b1;
        end else if (out_fire) begin
          state_n  = ST_EMPTY;
          clr_main = 1'b1;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          state_n      = ST_ONE;
          ld_main_skid = 1'b1;
          clr_skid     = 1'b1;
        end
      end
      default: begin
        state_n  = ST_EMPTY;
        clr_main = 1'b1;
        clr_skid = 1'b1;
      end
    endcase
    // Flush wins over everything; an accepted input is dropped here.
    if (flush) begin
      state_n      = ST_EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      clr_main     = 1'b1;
      clr_skid     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != ST_TWO);
    end
  end

  // Control is zeroed on every path into EMPTY; payload is left as is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (ld_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (ld_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end else if (clr_main) begin
        main_ctrl <= '0;
      end
      if (ld_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end else if (clr_skid) begin
        skid_ctrl <= '0;
      end
    end
  end

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~er),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~out_valid),
    .count (bubble_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid build and a no-skid build with 4-bit
// counters, each shadowed by a queue-based occupancy model.
module tb_pipe_stage_skid;

  localparam int CW = 8;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          rst1, iv1, ir1, ov1, ordy1, hold1, fl1;
  logic [CW-1:0] ictl1, octl1;
  logic [DW-1:0] idat1, odat1;
  logic [15:0]   stall1, bub1, flc1;
  logic [1:0]    st1;

  logic          rst0, iv0, ir0, ov0, ordy0, hold0, fl0;
  logic [CW-1:0] ictl0, octl0;
  logic [DW-1:0] idat0, odat0;
  logic [3:0]    stall0, bub0, flc0;
  logic [1:0]    st0;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .in_ctrl(ictl1),
    .in_data(idat1), .out_valid(ov1), .out_ready(ordy1), .out_ctrl(octl1),
    .out_data(odat1), .hold(hold1), .flush(fl1), .stall_cnt(stall1),
    .bubble_cnt(bub1), .flush_cnt(flc1), .state_dbg(st1)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .in_ctrl(ictl0),
    .in_data(idat0), .out_valid(ov0), .out_ready(ordy0), .out_ctrl(octl0),
    .out_data(odat0), .hold(hold0), .flush(fl0), .stall_cnt(stall0),
    .bubble_cnt(bub0), .flush_cnt(flc0), .state_dbg(st0)
  );

  assign idat1 = {ictl1, ictl1 ^ 8'h5A};
  assign idat0 = {ictl0, ictl0 ^ 8'hA5};

  // ---------------- scoreboard bookkeeping ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] got1_q[$];
  logic [CW-1:0] got0_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_got(input string name, input bit sel);
    logic [CW-1:0] g[$];
    if (sel) g = got1_q; else g = got0_q;
    chk({name, "_len"}, g.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < g.size()) chk({name, "_item"}, g[i], exp_q[i]);
    exp_q.delete();
    got1_q.delete();
    got0_q.delete();
  endtask

  // Items actually handed downstream (pre-edge values).
  always @(posedge clk) begin
    if (!rst1 && ov1 && ordy1 && !hold1) got1_q.push_back(octl1);
    if (!rst0 && ov0 && ordy0 && !hold0) got0_q.push_back(octl0);
  end

  // ---------------- behavioural models ----------------
  // Each model is just the list of held items plus counters.
  logic [CW+DW-1:0] m1_q[$];
  logic [CW+DW-1:0] m0_q[$];
  logic             m1_rdy;
  int               m1_stall, m1_bub, m1_fl, m0_stall, m0_bub, m0_fl;

  function automatic int sat(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  always @(posedge clk or posedge rst1) begin
    if (rst1) begin
      m1_q.delete(); m1_rdy = 1'b0; m1_stall = 0; m1_bub = 0; m1_fl = 0;
    end else begin
      automatic bit er = ordy1 & ~hold1;
      automatic bit ofire = (m1_q.size() != 0) && er;
      automatic bit ifire = iv1 && m1_rdy;
      if (m1_q.size() != 0 && !er) m1_stall = sat(m1_stall, 65535);
      if (m1_q.size() == 0) m1_bub = sat(m1_bub, 65535);
      if (fl1) m1_fl = sat(m1_fl, 65535);
      if (ofire) void'(m1_q.pop_front());
      if (fl1) m1_q.delete();
      else if (ifire) m1_q.push_back({ictl1, idat1});
      m1_rdy = (m1_q.size() < 2);
    end
  end

  function automatic bit m0_rdy();
    return !rst0 && ((m0_q.size() == 0) || (ordy0 && !hold0));
  endfunction

  always @(posedge clk or posedge rst0) begin
    if (rst0) begin
      m0_q.delete(); m0_stall = 0; m0_bub = 0; m0_fl = 0;
    end else begin
      automatic bit er = ordy0 & ~hold0;
      automatic bit ofire = (m0_q.size() != 0) && er;
      automatic bit ifire = iv0 && m0_rdy();
      if (m0_q.size() != 0 && !er) m0_stall = sat(m0_stall, 15);
      if (m0_q.size() == 0) m0_bub = sat(m0_bub, 15);
      if (fl0) m0_fl = sat(m0_fl, 15);
      if (ofire) void'(m0_q.pop_front());
      if (fl0) m0_q.delete();
      else if (ifire) m0_q.push_back({ictl0, idat0});
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("m1_valid", ov1, m1_q.size() != 0);
    chk("m1_ctrl", octl1, (m1_q.size() != 0) ? m1_q[0][CW+DW-1:DW] : '0);
    if (m1_q.size() != 0) chk("m1_data", odat1, m1_q[0][DW-1:0]);
    chk("m1_ready", ir1, m1_rdy);
    chk("m1_state", st1, m1_q.size());
    chk("m1_stall", stall1, m1_stall);
    chk("m1_bubble", bub1, m1_bub);
    chk("m1_flush", flc1, m1_fl);
    chk("m0_valid", ov0, m0_q.size() != 0);
    chk("m0_ctrl", octl0, (m0_q.size() != 0) ? m0_q[0][CW+DW-1:DW] : '0);
    if (m0_q.size() != 0) chk("m0_data", odat0, m0_q[0][DW-1:0]);
    chk("m0_ready", ir0, m0_rdy());
    chk("m0_state", st0, m0_q.size());
    chk("m0_stall", stall0, m0_stall);
    chk("m0_bubble", bub0, m0_bub);
    chk("m0_flush", flc0, m0_fl);
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst1 = 1'b1; iv1 = 0; ictl1 = '0; ordy1 = 1; hold1 = 0; fl1 = 0;
    rst0 = 1'b1; iv0 = 0; ictl0 = '0; ordy0 = 0; hold0 = 0; fl0 = 0;
    tick(); tick();
    rst1 = 1'b0;
    chk("rdy_in_reset_release", ir1, 1'b0);
    tick();
    chk("rdy_after_rst", ir1, 1'b1);

    // Reset in the middle of traffic
    iv1 = 1; ictl1 = 8'hA1; tick();
    ictl1 = 8'hB2; tick();
    iv1 = 0;
    #2 rst1 = 1'b1;
    #1;
    chk("midrst_valid", ov1, 1'b0);
    chk("midrst_ctrl", octl1, 8'h00);
    chk("midrst_bubble", bub1, 16'd0);
    chk("midrst_stall", stall1, 16'd0);
    chk("midrst_ready", ir1, 1'b0);
    tick();
    rst1 = 1'b0;
    tick();
    chk("rdy_after_midrst", ir1, 1'b1);
    got1_q.delete();

    // Streaming 1..8 with 1-cycle latency
    for (int i = 1; i <= 8; i++) begin
      iv1 = 1; ictl1 = CW'(i); tick();
      chk("stream_valid", ov1, 1'b1);
      chk("stream_latency", octl1, i);
    end
    iv1 = 0; tick();
    chk("stream_stall", stall1, 16'd0);
    for (int i = 1; i <= 8; i++) exp_q.push_back(CW'(i));
    check_got("stream_order", 1'b1);

    // Backpressure into the skid entry
    iv1 = 1; ictl1 = 8'd5; ordy1 = 1; tick();
    ordy1 = 0; ictl1 = 8'd6; tick();
    ictl1 = 8'd7; tick(); tick();
    chk("bp_state", st1, 2'd2);
    chk("bp_ready", ir1, 1'b0);
    chk("bp_stall", stall1, 16'd3);
    chk("bp_head", octl1, 8'd5);
    ordy1 = 1; tick(); tick();
    iv1 = 0; tick();
    exp_q = '{8'd5, 8'd6, 8'd7};
    check_got("bp_order", 1'b1);

    // Hold freezes the output for three cycles
    iv1 = 1; ictl1 = 8'd9; tick();
    hold1 = 1; iv1 = 0; tick(); tick(); tick();
    chk("hold_stall", stall1, 16'd6);
    chk("hold_head", octl1, 8'd9);
    hold1 = 0; iv1 = 1; ictl1 = 8'd10; tick();
    iv1 = 0; tick();
    exp_q = '{8'd9, 8'd10};
    check_got("hold_order", 1'b1);

    // Flush while full, with an input offered
    ordy1 = 0; iv1 = 1; ictl1 = 8'h21; tick();
    ictl1 = 8'h22; tick();
    fl1 = 1; ictl1 = 8'h23; tick();
    fl1 = 0; iv1 = 0;
    chk("flush_valid", ov1, 1'b0);
    chk("flush_ctrl", octl1, 8'h00);
    chk("flush_cnt1", flc1, 16'd1);
    chk("flush_ready", ir1, 1'b1);
    ordy1 = 1; tick();
    chk("flush_dropped", ov1, 1'b0);
    check_got("flush_none", 1'b1);

    // Flush together with a delivery
    iv1 = 1; ictl1 = 8'h31; tick();
    fl1 = 1; ictl1 = 8'h32; tick();
    fl1 = 0; iv1 = 0;
    chk("flush_fire_valid", ov1, 1'b0);
    chk("flush_cnt2", flc1, 16'd2);
    tick();
    exp_q = '{8'h31};
    check_got("flush_fire_order", 1'b1);

    // Flush under hold
    iv1 = 1; ictl1 = 8'h41; tick();
    hold1 = 1; fl1 = 1; iv1 = 0; tick();
    fl1 = 0; hold1 = 0;
    chk("flush_hold_valid", ov1, 1'b0);
    chk("flush_hold_ctrl", octl1, 8'h00);
    chk("flush_cnt3", flc1, 16'd3);
    check_got("flush_hold_none", 1'b1);

    // No-skid build: counter saturation
    rst0 = 1'b0;
    repeat (20) tick();
    chk("sat_bubble", bub0, 4'd15);
    chk("sat_stall", stall0, 4'd0);
    chk("sat_flush", flc0, 4'd0);

    // No-skid build: toggling out_ready
    for (int k = 0; k < 8; k++) begin
      iv0 = 1; ictl0 = 8'h50 + CW'(k); ordy0 = k[0];
      #1;
      chk("comb_ready", ir0, (k == 0) || k[0]);
      tick();
    end
    iv0 = 0; ordy0 = 1; tick(); tick();
    exp_q = '{8'h50, 8'h51, 8'h53, 8'h55, 8'h57};
    check_got("toggle_order", 1'b0);
    chk("toggle_stall", stall0, 4'd3);
    chk("toggle_bubble", bub0, 4'd15);

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
